// File: rtl/ysyx_25010008_ifu.sv
// Instruction fetch unit for a multicycle core with one instruction in flight.
// It fetches the word at pc over a single-beat AR/R channel and holds it on inst
// until decode accepts it. It then waits for the next pc from execute/writeback.
module ysyx_25010008_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_i,
  input  logic        npc_valid_i,
  output logic        npc_ready_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        ivalid_o,
  input  logic        idu_ready_i,
  output logic        ifault_o,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rvalid_i,
  output logic        rready_o
);

  typedef enum logic [2:0] {StIdle, StFetch, StWaitR, StHold, StWaitNpc} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        ifault_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        ivalid_q;
  logic        npc_ready_q;

  // FSM with registered handshake flags. Each flag is set on the same edge that enters its
  // state, so every output is a clean register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      ifault_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      ivalid_q    <= 1'b0;
      npc_ready_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q   <= StFetch;
          arvalid_q <= 1'b1;
        end
        StFetch: begin
          // rvalid is deliberately not looked at until the address has been accepted
          if (arready_i) begin
            state_q   <= StWaitR;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        StWaitR: begin
          if (rvalid_i) begin
            state_q  <= StHold;
            rready_q <= 1'b0;
            ivalid_q <= 1'b1;
            if (rresp_i == 2'b00) begin
              inst_q   <= rdata_i;
              ifault_q <= 1'b0;
            end else begin
              inst_q   <= NOP_INST;
              ifault_q <= 1'b1;
            end
          end
        end
        StHold: begin
          if (idu_ready_i) begin
            state_q     <= StWaitNpc;
            ivalid_q    <= 1'b0;
            npc_ready_q <= 1'b1;
          end
        end
        StWaitNpc: begin
          if (npc_valid_i) begin
            pc_q        <= npc_i;
            npc_ready_q <= 1'b0;
            if (npc_i[1:0] == 2'b00) begin
              state_q   <= StFetch;
              arvalid_q <= 1'b1;
            end else begin
              // A misaligned target faults locally and makes no bus access.
              state_q  <= StHold;
              ivalid_q <= 1'b1;
              inst_q   <= NOP_INST;
              ifault_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
          ivalid_q    <= 1'b0;
          npc_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign araddr_o    = pc_q;
  assign inst_o      = inst_q;
  assign ifault_o    = ifault_q;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = rready_q;
  assign ivalid_o    = ivalid_q;
  assign npc_ready_o = npc_ready_q;

endmodule

// File: tb/tb_ysyx_25010008_ifu.sv
// Bench for the fetch unit. It plays the memory and decode/execute sides cycle by cycle and
// checks each held instruction against a transaction-level expectation.
module tb_ysyx_25010008_ifu;

  localparam logic [31:0] ResetPc = 32'h8000_0000;
  localparam logic [31:0] NopInst = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc;
  logic        npc_valid;
  logic        npc_ready;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        ivalid;
  logic        idu_ready;
  logic        ifault;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks   = 0;
  int failures = 0;

  // Transaction-level expectation for the instruction currently held.
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic        exp_fault;
  logic        need_fetch;

  ysyx_25010008_ifu #(
    .RESET_PC(ResetPc),
    .NOP_INST(NopInst)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .npc_i      (npc),
    .npc_valid_i(npc_valid),
    .npc_ready_o(npc_ready),
    .pc_o       (pc),
    .inst_o     (inst),
    .ivalid_o   (ivalid),
    .idu_ready_i(idu_ready),
    .ifault_o   (ifault),
    .araddr_o   (araddr),
    .arvalid_o  (arvalid),
    .arready_i  (arready),
    .rdata_i    (rdata),
    .rresp_i    (rresp),
    .rvalid_i   (rvalid),
    .rready_o   (rready)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed word at the reset vector, a scrambled address elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == ResetPc) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serves one fetch of addr. It is entered with the DUT presenting arvalid and leaves
  // right after the R beat.
  task automatic serve_fetch(input logic [31:0] addr, input int ar_wait, input int r_wait,
                             input logic [1:0] resp);
    logic [31:0] junk;
    checks++;
    if ({arvalid, rready, ivalid, npc_ready} !== 4'b1000 || araddr !== addr) begin
      failures++;
      $display("FAIL fetch_entry: flags=%b araddr=%h want flags=1000 araddr=%h",
               {arvalid, rready, ivalid, npc_ready}, araddr, addr);
    end
    for (int c = 0; c < ar_wait; c++) begin
      // Stray rvalid and npc_valid while fetching must not be taken.
      junk      = $urandom;
      arready   = 1'b0;
      rvalid    = 1'b1;
      rdata     = 32'hDEAD_BEEF;
      npc_valid = 1'b1;
      npc       = junk;
      step();
      checks++;
      if ({arvalid, rready, ivalid, npc_ready} !== 4'b1000 || araddr !== addr) begin
        failures++;
        $display("FAIL ar_stall: flags=%b araddr=%h want flags=1000 araddr=%h",
                 {arvalid, rready, ivalid, npc_ready}, araddr, addr);
      end
    end
    rvalid    = 1'b0;
    npc_valid = 1'b0;
    arready   = 1'b1;
    step();
    arready = 1'b0;
    checks++;
    if ({arvalid, rready, ivalid, npc_ready} !== 4'b0100) begin
      failures++;
      $display("FAIL wait_r: flags=%b want 0100", {arvalid, rready, ivalid, npc_ready});
    end
    for (int c = 0; c < r_wait; c++) begin
      step();
      checks++;
      if ({arvalid, rready, ivalid, npc_ready} !== 4'b0100) begin
        failures++;
        $display("FAIL r_stall: flags=%b want 0100", {arvalid, rready, ivalid, npc_ready});
      end
    end
    rvalid = 1'b1;
    rdata  = mem_word(addr);
    rresp  = resp;
    step();
    rvalid    = 1'b0;
    rresp     = 2'b00;
    exp_pc    = addr;
    exp_inst  = (resp == 2'b00) ? mem_word(addr) : NopInst;
    exp_fault = (resp != 2'b00);
  endtask

  // Checks the held instruction for hwait stalled cycles, then lets decode take it.
  task automatic hold_and_accept(input int hwait);
    logic [31:0] junk;
    for (int c = 0; c <= hwait; c++) begin
      if (c != 0) begin
        junk      = $urandom;
        idu_ready = 1'b0;
        npc_valid = 1'b1;
        npc       = junk;
        step();
      end
      checks++;
      if ({arvalid, rready, ivalid, npc_ready} !== 4'b0010 || pc !== exp_pc ||
          inst !== exp_inst || ifault !== exp_fault) begin
        failures++;
        $display("FAIL hold: flags=%b pc=%h inst=%h ifault=%b want flags=0010 pc=%h inst=%h ifault=%b",
                 {arvalid, rready, ivalid, npc_ready}, pc, inst, ifault,
                 exp_pc, exp_inst, exp_fault);
      end
    end
    npc_valid = 1'b0;
    idu_ready = 1'b1;
    step();
    idu_ready = 1'b0;
    checks++;
    if ({arvalid, rready, ivalid, npc_ready} !== 4'b0001 || pc !== exp_pc) begin
      failures++;
      $display("FAIL wait_npc: flags=%b pc=%h want flags=0001 pc=%h",
               {arvalid, rready, ivalid, npc_ready}, pc, exp_pc);
    end
  endtask

  // Offers the next pc after nwait idle cycles and checks where the unit goes.
  task automatic give_npc(input logic [31:0] addr, input int nwait);
    for (int c = 0; c < nwait; c++) begin
      npc_valid = 1'b0;
      step();
      checks++;
      if ({arvalid, rready, ivalid, npc_ready} !== 4'b0001) begin
        failures++;
        $display("FAIL npc_stall: flags=%b want 0001", {arvalid, rready, ivalid, npc_ready});
      end
    end
    npc       = addr;
    npc_valid = 1'b1;
    step();
    npc_valid = 1'b0;
    exp_pc    = addr;
    if (addr[1:0] == 2'b00) begin
      need_fetch = 1'b1;
      checks++;
      if ({arvalid, rready, ivalid, npc_ready} !== 4'b1000 || araddr !== addr) begin
        failures++;
        $display("FAIL npc_fetch: flags=%b araddr=%h want flags=1000 araddr=%h",
                 {arvalid, rready, ivalid, npc_ready}, araddr, addr);
      end
    end else begin
      need_fetch = 1'b0;
      exp_inst   = NopInst;
      exp_fault  = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    npc       = '0;
    npc_valid = 1'b0;
    idu_ready = 1'b0;
    arready   = 1'b0;
    rdata     = '0;
    rresp     = 2'b00;
    rvalid    = 1'b0;
    #1;
    step();
    checks++;
    if ({arvalid, rready, ivalid, npc_ready} !== 4'b0000 || pc !== ResetPc ||
        inst !== NopInst || ifault !== 1'b0) begin
      failures++;
      $display("FAIL reset: flags=%b pc=%h inst=%h ifault=%b want 0000 %h %h 0",
               {arvalid, rready, ivalid, npc_ready}, pc, inst, ifault, ResetPc, NopInst);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({arvalid, rready, ivalid, npc_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL idle: flags=%b want 0000", {arvalid, rready, ivalid, npc_ready});
    end
    step();
    exp_pc     = ResetPc;
    need_fetch = 1'b1;
  endtask

  task automatic test_first_fetch();
    serve_fetch(ResetPc, 0, 0, 2'b00);
    checks++;
    if (inst !== 32'h0010_0093 || ivalid !== 1'b1 || ifault !== 1'b0) begin
      failures++;
      $display("FAIL first_fetch: inst=%h ivalid=%b ifault=%b want 00100093 1 0",
               inst, ivalid, ifault);
    end
    hold_and_accept(0);
    give_npc(32'h8000_0004, 0);
  endtask

  task automatic test_backpressure();
    serve_fetch(32'h8000_0004, 4, 0, 2'b00);
    hold_and_accept(5);
    give_npc(32'h8000_0008, 2);
  endtask

  task automatic test_bus_error();
    serve_fetch(32'h8000_0008, 0, 1, 2'b10);
    checks++;
    if (inst !== NopInst || ifault !== 1'b1 || ivalid !== 1'b1) begin
      failures++;
      $display("FAIL bus_error: inst=%h ifault=%b ivalid=%b want %h 1 1",
               inst, ifault, ivalid, NopInst);
    end
    hold_and_accept(1);
    give_npc(32'h8000_000C, 0);
    serve_fetch(32'h8000_000C, 0, 0, 2'b00);
    checks++;
    if (ifault !== 1'b0) begin
      failures++;
      $display("FAIL fault_clear: ifault=%b want 0", ifault);
    end
    hold_and_accept(0);
  endtask

  task automatic test_misaligned();
    give_npc(32'h8000_0002, 0);
    hold_and_accept(2);
    give_npc(32'h8000_0010, 0);
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 60; i++) begin
      if (need_fetch) begin
        serve_fetch(exp_pc, int'($urandom_range(3)), int'($urandom_range(3)),
                    ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00);
      end
      hold_and_accept(int'($urandom_range(3)));
      r = $urandom;
      if ($urandom_range(5) == 0) begin
        if (r[1:0] == 2'b00) r[0] = 1'b1;
      end else begin
        r[1:0] = 2'b00;
      end
      give_npc(r, int'($urandom_range(2)));
    end
    if (!need_fetch) begin
      hold_and_accept(0);
      give_npc(32'h8000_0100, 0);
    end
  endtask

  task automatic test_reset_in_wait_r();
    arready = 1'b1;
    step();
    arready = 1'b0;
    checks++;
    if (rready !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_wait_r: rready=%b want 1", rready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({arvalid, rready, ivalid, npc_ready} !== 4'b0000 || pc !== ResetPc) begin
      failures++;
      $display("FAIL async_reset: flags=%b pc=%h want 0000 %h",
               {arvalid, rready, ivalid, npc_ready}, pc, ResetPc);
    end
    step();
    rst_n = 1'b1;
    step();
    exp_pc = ResetPc;
    serve_fetch(ResetPc, 1, 0, 2'b00);
    hold_and_accept(0);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_bus_error();
    test_misaligned();
    test_random();
    test_reset_in_wait_r();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
